regfile_write_queue: RTL

- Initiator side of the register file write port (write_addr / write_data / reg_write) in the 16-bit MIPS datapath.
- Accepts writeback requests from variable-latency producers through a valid/ready handshake and buffers them in order in a small FIFO.
- Drains one entry per cycle into the register file whenever the file accepts a write.
- Provides two read-bypass lookups (rs, rt), so pending writes are visible before they commit.

---
 rtl/regfile_write_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   In-order writeback buffer in front of the register file write port.
//   Producers hand over {addr, data} on a valid/ready handshake. Entries
//   drain one per cycle whenever the register file is ready. Two
//   combinational bypass lookups (rs, rt) expose the youngest pending value
//   for an address before it commits.
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   req_valid/req_ready       producer handshake
//   req_addr/req_data         writeback request payload
//   rf_ready                  register file accepts a write this cycle
//   rf_write/_addr/_data      write strobe and head entry toward the file
//   rs_addr/rs_hit/rs_data    bypass lookup A
//   rt_addr/rt_hit/rt_data    bypass lookup B
//   count                     number of pending entries
module regfile_write_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     rf_ready,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_write_addr,
  output logic [DATA_W-1:0]        rf_write_data,
  input  logic [ADDR_W-1:0]        rs_addr,
  output logic                     rs_hit,
  output logic [DATA_W-1:0]        rs_data,
  input  logic [ADDR_W-1:0]        rt_addr,
  output logic                     rt_hit,
  output logic [DATA_W-1:0]        rt_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [DEPTH-1:0]             ent_vld;
  logic [PTR_W-1:0]             head, tail;
  logic                         push, pop, not_empty;

  assign not_empty = (count != '0);
  // Full-queue stall is based on registered count only; a same-cycle pop
  // does not open a slot for the producer.
  assign req_ready = (count < CNT_W'(DEPTH));
  // Writes to register 0 are accepted and silently dropped.
  assign push      = req_valid & req_ready & (req_addr != '0);
  assign pop       = rf_write;

  assign rf_write      = not_empty & rf_ready;
  assign rf_write_addr = not_empty ? ent_addr[head] : '0;
  assign rf_write_data = not_empty ? ent_data[head] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_vld  <= '0;
      ent_addr <= '0;
      ent_data <= '0;
    end else begin
      // Push and pop never target the same slot: a push needs count<DEPTH,
      // a pop needs count>0, so head==tail cannot hold with both active.
      if (push) begin
        ent_addr[tail] <= req_addr;
        ent_data[tail] <= req_data;
        ent_vld[tail]  <= 1'b1;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk entries oldest to youngest starting at head; later matches
  // overwrite earlier ones so the youngest pending value wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    d   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((a != '0) && ent_vld[idx] && (ent_addr[idx] == a)) begin
        hit = 1'b1;
        d   = ent_data[idx];
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {rs_hit, rs_data} = lookup(rs_addr);
    {rt_hit, rt_data} = lookup(rt_addr);
  end

endmodule
